// File: rtl/serial_adder_param.sv
// Multi-cycle adder: DIGIT bits per clock, LSB chunk first, start/busy/done handshake.
// Optional subtract mode enabled by defining SERIAL_ADDER_SUB_EN (adds the 'sub' port).
module serial_adder_param #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int N  = (DIGIT >= 1) ? WIDTH / DIGIT : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_adder_param: need WIDTH>=1, 1<=DIGIT<=WIDTH, WIDTH%%DIGIT==0");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic [31:0]      base;
  logic [DIGIT-1:0] a_chunk, b_chunk;
  logic [DIGIT:0]   chunk;
  logic             sub_i;
  logic             last;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    last     = (cnt == LAST);
    base     = 32'(cnt) * 32'(DIGIT);
    a_chunk  = a_q[base +: DIGIT];
    b_chunk  = b_q[base +: DIGIT];
    chunk    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{DIGIT{1'b0}}, carry_q};
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1, so cout=1 reads as "no borrow".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub_i ? ~b : b;
            carry_q <= sub_i ? 1'b1 : cin;
            cnt     <= '0;
          end
        end
        RUN: begin
          sum[base +: DIGIT] <= chunk[DIGIT-1:0];
          carry_q            <= chunk[DIGIT];
          if (last) cout <= chunk[DIGIT];
          else      cnt  <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_param.sv
// Self-checking bench for serial_adder_param: vector table, hand-written corner sequences,
// randomized ops against an arithmetic reference model (WIDTH 8/2, 1/1 and 16/4 instances).
module tb_serial_adder_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       start8, cin8, sub8, cout8, busy8, done8;
  logic [7:0] a8, b8, sum8;
  logic       start1, a1, b1, cin1, sub1, sum1, cout1, busy1, done1;
  logic        start16, cin16, sub16, cout16, busy16, done16;
  logic [15:0] a16, b16, sum16;

  serial_adder_param #(.WIDTH(8), .DIGIT(2)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .sum(sum8), .cout(cout8), .busy(busy8), .done(done8)
  );

  serial_adder_param #(.WIDTH(1), .DIGIT(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub1),
`endif
    .sum(sum1), .cout(cout1), .busy(busy1), .done(done1)
  );

  serial_adder_param #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub16),
`endif
    .sum(sum16), .cout(cout16), .busy(busy16), .done(done16)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // One operation on the 8-bit instance; operands are scrambled right after acceptance.
  task automatic op8(input logic [7:0] aa, input logic [7:0] bb, input logic c, input logic s,
                     output logic [7:0] rs, output logic rc, output int nbusy);
    logic [7:0] old;
    int guard;
    @(negedge clk);
    old = sum8;
    a8 = aa; b8 = bb; cin8 = c; sub8 = s; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
    chk("sum_held_until_run", {24'h0, sum8}, {24'h0, old});
    nbusy = 0;
    guard = 0;
    while (!done8 && guard < 20) begin
      if (busy8) nbusy++;
      @(negedge clk);
      guard++;
    end
    if (!done8) chk("op8_done_timeout", 32'd0, 32'd1);
    rs = sum8;
    rc = cout8;
    chk("busy_low_at_done", {31'h0, busy8}, 32'd0);
    @(negedge clk);
    chk("done_single_cycle", {31'h0, done8}, 32'd0);
    chk("sum_held_after_done", {24'h0, sum8}, {24'h0, rs});
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t tab[8];

  initial begin
    logic [7:0] rs;
    logic       rc;
    int         nb;
    int         cyc, t1, t2, ndone, guard;
    logic [7:0] s1, s2;
    logic       c1, c2, prev_done, bad_consec;

    tab[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tab[1] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1};
    tab[2] = '{8'h5A, 8'hA5, 1'b0, 8'hFF, 1'b0};
    tab[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tab[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tab[5] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
    tab[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    tab[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

    rst = 1'b1;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
    start1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0;
    start16 = 0; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0;
    repeat (2) @(negedge clk);
    chk("reset_state", {22'h0, sum8, cout8, busy8, done8}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_after_reset", {22'h0, sum8, cout8, busy8, done8}, 32'd0);
    end

    for (int i = 0; i < 8; i++) begin
      op8(tab[i].a, tab[i].b, tab[i].cin, 1'b0, rs, rc, nb);
      chk("vec_sum", {24'h0, rs}, {24'h0, tab[i].sum});
      chk("vec_cout", {31'h0, rc}, {31'h0, tab[i].cout});
      chk("vec_busy_cycles", nb, 32'd4);
    end

`ifdef SERIAL_ADDER_SUB_EN
    op8(8'h05, 8'h07, 1'b0, 1'b1, rs, rc, nb);
    chk("sub_5_7_sum", {24'h0, rs}, 32'hFE);
    chk("sub_5_7_cout", {31'h0, rc}, 32'd0);
    op8(8'h07, 8'h05, 1'b0, 1'b1, rs, rc, nb);
    chk("sub_7_5_sum", {24'h0, rs}, 32'h02);
    chk("sub_7_5_cout", {31'h0, rc}, 32'd1);
`endif

    // start held high; operands changed mid-run must not leak into the first result
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 0; sub8 = 0; start8 = 1'b1;
    cyc = 0; t1 = -1; t2 = -1; ndone = 0; prev_done = 0; bad_consec = 0;
    s1 = 0; s2 = 0; c1 = 0; c2 = 0;
    while (ndone < 2 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) begin a8 = 8'h77; b8 = 8'h77; end
      if (done8 && prev_done) bad_consec = 1'b1;
      if (done8) begin
        ndone++;
        if (ndone == 1) begin t1 = cyc; s1 = sum8; c1 = cout8; end
        else begin t2 = cyc; s2 = sum8; c2 = cout8; start8 = 1'b0; end
      end
      prev_done = done8;
    end
    start8 = 1'b0;
    chk("held_start_done_count", ndone, 32'd2);
    chk("held_start_first_latency", t1, 32'd5);
    chk("held_start_first_sum", {24'h0, s1}, 32'h30);
    chk("held_start_first_cout", {31'h0, c1}, 32'd0);
    chk("held_start_reaccept_gap", t2 - t1, 32'd6);
    chk("held_start_second_sum", {24'h0, s2}, 32'hEE);
    chk("held_start_second_cout", {31'h0, c2}, 32'd0);
    chk("done_never_consecutive", {31'h0, bad_consec}, 32'd0);
    repeat (2) @(negedge clk);

    // reset after two RUN edges
    a8 = 8'h80; b8 = 8'h80; cin8 = 0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_before_mid_reset", {31'h0, busy8}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_reset_async_clear", {22'h0, sum8, cout8, busy8, done8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done8 || busy8) ndone++;
    end
    chk("no_activity_after_mid_reset", ndone, 32'd0);

    // single-bit instance against the full-adder truth table
    for (int i = 0; i < 8; i++) begin
      int v, e;
      v = i;
      e = v[2] + v[1] + v[0];
      @(negedge clk);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; sub1 = 0; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("fa_busy", {31'h0, busy1}, 32'd1);
      guard = 0;
      while (!done1 && guard < 10) begin @(negedge clk); guard++; end
      chk("fa_latency_cycles", guard, 32'd1);
      chk("fa_sum", {31'h0, sum1}, e & 1);
      chk("fa_cout", {31'h0, cout1}, e >> 1);
    end

    // random 8-bit ops vs plain arithmetic
    for (int i = 0; i < 100; i++) begin
      int unsigned ra, rb, rci, rsub, full, es, ec;
      ra = $urandom_range(255); rb = $urandom_range(255); rci = $urandom_range(1);
`ifdef SERIAL_ADDER_SUB_EN
      rsub = $urandom_range(1);
`else
      rsub = 0;
`endif
      if (rsub != 0) begin
        es = (ra - rb) % 256; ec = (ra >= rb) ? 1 : 0;
      end else begin
        full = ra + rb + rci; es = full % 256; ec = full / 256;
      end
      op8(8'(ra), 8'(rb), 1'(rci), 1'(rsub), rs, rc, nb);
      chk("rand8_sum", {24'h0, rs}, es);
      chk("rand8_cout", {31'h0, rc}, ec);
    end

    // random 16-bit, 4-bit digit ops
    for (int i = 0; i < 1000; i++) begin
      int unsigned ra, rb, rci, rsub, full, es, ec;
      ra = $urandom_range(65535); rb = $urandom_range(65535); rci = $urandom_range(1);
`ifdef SERIAL_ADDER_SUB_EN
      rsub = $urandom_range(1);
`else
      rsub = 0;
`endif
      if (rsub != 0) begin
        es = (ra - rb) % 65536; ec = (ra >= rb) ? 1 : 0;
      end else begin
        full = ra + rb + rci; es = full % 65536; ec = full / 65536;
      end
      @(negedge clk);
      a16 = 16'(ra); b16 = 16'(rb); cin16 = 1'(rci); sub16 = 1'(rsub); start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); sub16 = 1'($urandom);
      guard = 0;
      while (!done16 && guard < 20) begin @(negedge clk); guard++; end
      if (!done16) chk("rand16_done_timeout", 32'd0, 32'd1);
      chk("rand16_sum", {16'h0, sum16}, es);
      chk("rand16_cout", {31'h0, cout16}, ec);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder_param.md
Name: serial_adder_param

Overview:
- Parametrised multi-cycle adder. It is the sequential successor to the single-bit full adder.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, LSB chunk first, using a carry register between chunks.
- Start/busy/done handshake, so datapath blocks can trade area for latency.
- Sits beside the combinational adders as a drop-in arithmetic unit for narrow-area paths.

Parameters:
- WIDTH, 8, operand and sum width in bits. Must be ≥1.
- DIGIT, 2, bits added per clock. Must be ≥1, ≤WIDTH, and WIDTH % DIGIT == 0; otherwise elaboration error.
- Derived: N = WIDTH/DIGIT chunk cycles. Chunk counter width = clog2(N), minimum 1.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- cin  input  1  carry-in, captured on accepted start.
- sum  output  WIDTH  result, valid while done=1, held until next accepted start.
- cout  output  1  carry-out of MSB, same validity as sum.
- busy  output  1  high during RUN.
- done  output  1  one-cycle pulse, result valid.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, sum=0, cout=0, busy=0, done=0, counter=0, carry reg=0, operand regs=0. Applies immediately, including mid-RUN or during DONE; any in-flight operation is discarded and no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0: latch a, b, cin into internal regs; clear counter; go to RUN. sum/cout keep old value until the first RUN edge.
  - start=0: stay in IDLE.
- RUN:
  - Each edge adds chunk[i] of A, chunk[i] of B and the carry reg with a full DIGIT-bit add.
  - Writes the DIGIT-bit result into sum[i*DIGIT +: DIGIT]; carry reg takes the chunk carry-out; counter increments.
  - After chunk N-1 is written: cout takes the final carry; go to DONE.
  - Chunk i=0 uses the latched cin.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE and RUN: no re-latch, no queueing.
- Timing:
  - start sampled at edge E0 → busy=1 after edges E0..E(N-1) → done=1 after edge EN.
  - Start-to-done latency = N clocks. Throughput = one op per N+2 clocks (start re-accepted at earliest in IDLE after DONE).
- busy = (state==RUN). done = (state==DONE). Both are registered; no combinational path from start.
- sum is partially updated during RUN; consumers sample it only on done.
- Operand inputs may change freely after the accepting edge.
- Arithmetic is modulo 2^WIDTH, with the overflow bit reported on cout.
- Degenerate case DIGIT==WIDTH: N=1, one RUN cycle.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Extra port sub (input, 1), captured with the operands.
  - When sub=1 the unit computes a - b: B reg loads ~b, initial carry forced to 1, cin ignored.
  - cout = 1 means no borrow (a ≥ b unsigned).
  - Timing is identical.
- Undefined: port absent; addition only.

Test Plan (WIDTH=8, DIGIT=2 unless stated):
- Reset then idle: rst pulse, no start → sum=0x00, cout=0, busy=0, done=0 for 20 cycles.
- Carry ripple across chunks: a=0xFF, b=0x01, cin=0, start one cycle → busy high 4 cycles, done pulse at 4th edge after start, sum=0x00, cout=1.
- Exhaustive carry-in: a=0x5A, b=0xA5, cin=1 → sum=0x00, cout=1. Then a=0x5A, b=0xA5, cin=0 → sum=0xFF, cout=0. Also all 8 single-bit combinations with WIDTH=1, DIGIT=1, matching the full-adder truth table.
- start ignored while busy: start held high continuously with a=0x10, b=0x20, and operands changed to 0x77 mid-RUN → first result sum=0x30. Next accept only after DONE → IDLE. done never pulses on consecutive cycles.
- Reset mid-operation: start a=0x80, b=0x80, assert rst after 2 RUN edges → sum=0, cout=0, busy=0 immediately; no done pulse afterwards.
- SERIAL_ADDER_SUB_EN: sub=1, a=0x05, b=0x07 → sum=0xFE, cout=0. sub=1, a=0x07, b=0x05 → sum=0x02, cout=1. Also WIDTH=16, DIGIT=4 random add/sub vs reference model, 1000 ops.
